// File: rtl/eth_link_pkg.sv
// -----------------------------------------------------------------------------
// eth_link_pkg
// Shared definitions for the RGMII transmit-side PHY bring-up / pacing block:
//   - two-bit TX speed codes (11 = 1000, 10 = 100, 01 = 10, 00 = stopped)
//   - bring-up FSM state encoding
//   - link_prio: priority encoder from the three link-status bits to a code
// -----------------------------------------------------------------------------
package eth_link_pkg;

   localparam logic [1:0] SPD_1000 = 2'b11;
   localparam logic [1:0] SPD_100  = 2'b10;
   localparam logic [1:0] SPD_10   = 2'b01;
   localparam logic [1:0] SPD_NONE = 2'b00;

   typedef enum logic [1:0] {
      ST_HOLD   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RUN    = 2'd2
   } pacer_state_t;

   // lnk = {link_1000mb, link_100mb, link_10mb}; fastest reported link wins
   function automatic logic [1:0] link_prio(input logic [2:0] lnk);
      if (lnk[2])      return SPD_1000;
      else if (lnk[1]) return SPD_100;
      else if (lnk[0]) return SPD_10;
      else             return SPD_NONE;
   endfunction

endpackage

// File: rtl/link_sync.sv
// -----------------------------------------------------------------------------
// link_sync
// Two-flop synchroniser for quasi-static status bits crossing into the local
// clock domain. Each bit is synchronised independently.
// Ports:
//   clk  in  1      destination clock
//   rst  in  1      synchronous active-high reset (outputs read 0)
//   d    in  WIDTH  asynchronous inputs
//   q    out WIDTH  synchronised outputs (2 cycles latency)
// -----------------------------------------------------------------------------
module link_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sync_p0;
   logic [WIDTH-1:0] sync_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         // stage 0: capture (may go metastable)
         sync_p0 <= d;
         // stage 1: resolved value
         sync_p1 <= sync_p0;
      end
   end

   assign q = sync_p1;

endmodule

// File: rtl/eth_link_pacer.sv
// -----------------------------------------------------------------------------
// eth_link_pacer
// PHY bring-up and transmit-pacing controller for the RGMII TX path.
// Sequences the PHY hardware reset (HOLD -> SETTLE -> RUN), selects the TX
// speed from debounced RX link status (committed only between frames), and
// generates the adv_data byte-advance strobe for the byte formatter.
// Ports:
//   clk125MHz      in  1  single clock
//   rstb           in  1  synchronous active-high reset
//   link_10mb      in  1  RX-domain link status, asynchronous
//   link_100mb     in  1  RX-domain link status, asynchronous
//   link_1000mb    in  1  RX-domain link status, asynchronous
//   tx_busy        in  1  high while a frame is being emitted
//   phy_rst_req    in  1  single-cycle request to re-run the PHY reset
//   eth_rst_b      out 1  PHY reset, active low
//   phy_ready      out 1  PHY out of reset and settled
//   speed          out 2  11 = 1000, 10 = 100, 01 = 10, 00 = stopped
//   adv_data       out 1  byte-advance strobe
//   link_up        out 1  accepted link code is non-zero
//   speed_changed  out 1  one-cycle pulse when speed updates
// -----------------------------------------------------------------------------
module eth_link_pacer
   import eth_link_pkg::*;
#(
   parameter int RST_HOLD      = 16777216,
   parameter int RST_SETTLE    = 16777216,
   parameter int DIV_100M      = 10,
   parameter int DIV_10M       = 100,
   parameter int LINK_DEBOUNCE = 1024
) (
   input  logic       clk125MHz,
   input  logic       rstb,
   input  logic       link_10mb,
   input  logic       link_100mb,
   input  logic       link_1000mb,
   input  logic       tx_busy,
   input  logic       phy_rst_req,
   output logic       eth_rst_b,
   output logic       phy_ready,
   output logic [1:0] speed,
   output logic       adv_data,
   output logic       link_up,
   output logic       speed_changed
);

   localparam int RST_MAX = (RST_HOLD > RST_SETTLE) ? RST_HOLD : RST_SETTLE;
   localparam int RCW     = $clog2(RST_MAX + 1);
   localparam int DIV_MAX = (DIV_10M > DIV_100M) ? DIV_10M : DIV_100M;
   localparam int DVW     = $clog2(DIV_MAX + 1);
   localparam int DBW     = $clog2(LINK_DEBOUNCE + 1);

   function automatic logic [RCW-1:0] rst_inc(input logic [RCW-1:0] v);
      return (v >= RCW'(RST_MAX)) ? v : v + RCW'(1);
   endfunction

   function automatic logic [DBW-1:0] dbn_inc(input logic [DBW-1:0] v);
      return (v >= DBW'(LINK_DEBOUNCE)) ? v : v + DBW'(1);
   endfunction

   pacer_state_t   state;
   logic [RCW-1:0] rst_cnt;

   logic [2:0]     link_sync_p1;
   logic [1:0]     cand;
   logic [1:0]     cand_q;
   logic [DBW-1:0] dbn_cnt;
   logic           acc_evt;
   logic           pend_vld;
   logic [1:0]     pend_code;
   logic           commit;
   logic [1:0]     spd_after;

   logic [DVW-1:0] div_cnt;
   logic [DVW-1:0] div_last;

   // ---------------------------------------------------------------- bring-up
   always_ff @(posedge clk125MHz) begin
      if (rstb) begin
         state     <= ST_HOLD;
         rst_cnt   <= '0;
         eth_rst_b <= 1'b0;
         phy_ready <= 1'b0;
      end else begin
         case (state)
            ST_HOLD: begin
               if (phy_rst_req) begin
                  rst_cnt <= '0;
               end else if (rst_cnt == RCW'(RST_HOLD - 1)) begin
                  state     <= ST_SETTLE;
                  rst_cnt   <= '0;
                  eth_rst_b <= 1'b1;
               end else begin
                  rst_cnt <= rst_inc(rst_cnt);
               end
            end
            ST_SETTLE: begin
               if (phy_rst_req) begin
                  state     <= ST_HOLD;
                  rst_cnt   <= '0;
                  eth_rst_b <= 1'b0;
               end else if (rst_cnt == RCW'(RST_SETTLE - 1)) begin
                  state     <= ST_RUN;
                  rst_cnt   <= '0;
                  phy_ready <= 1'b1;
               end else begin
                  rst_cnt <= rst_inc(rst_cnt);
               end
            end
            ST_RUN: begin
               if (phy_rst_req) begin
                  state     <= ST_HOLD;
                  rst_cnt   <= '0;
                  eth_rst_b <= 1'b0;
                  phy_ready <= 1'b0;
               end
            end
            default: begin
               state     <= ST_HOLD;
               rst_cnt   <= '0;
               eth_rst_b <= 1'b0;
               phy_ready <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------- link status: sync (stages p0/p1)
   link_sync #(.WIDTH(3)) u_link_sync (
      .clk (clk125MHz),
      .rst (rstb),
      .d   ({link_1000mb, link_100mb, link_10mb}),
      .q   (link_sync_p1)
   );

   // An acceptance event fires once, on the cycle the candidate completes its
   // LINK_DEBOUNCE-long stable run. The pending code is compared against the
   // speed as it will be after any same-cycle commit.
   always_comb begin
      cand = link_prio(link_sync_p1);
      if (cand != cand_q) acc_evt = (LINK_DEBOUNCE == 1);
      else                acc_evt = (dbn_cnt == DBW'(LINK_DEBOUNCE - 1));
      commit    = pend_vld && !tx_busy && (state == ST_RUN);
      spd_after = commit ? pend_code : speed;
   end

   // ---------------------------------------------------- debounce / commit
   always_ff @(posedge clk125MHz) begin
      if (rstb) begin
         cand_q        <= SPD_NONE;
         dbn_cnt       <= '0;
         pend_vld      <= 1'b0;
         pend_code     <= SPD_NONE;
         speed         <= SPD_1000;
         link_up       <= 1'b0;
         speed_changed <= 1'b0;
      end else begin
         speed_changed <= commit;
         if (commit) speed <= pend_code;

         if (cand != cand_q) begin
            cand_q  <= cand;
            dbn_cnt <= DBW'(1);
         end else begin
            dbn_cnt <= dbn_inc(dbn_cnt);
         end

         if (acc_evt) begin
            link_up   <= (cand != SPD_NONE);
            pend_code <= cand;
            pend_vld  <= (cand != spd_after);
         end else if (commit) begin
            pend_vld <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------- pacing
   assign div_last = (speed == SPD_10) ? DVW'(DIV_10M - 1) : DVW'(DIV_100M - 1);

   // The strobe uses the speed in force before this edge; a commit edge emits
   // nothing so the first strobe of the new rate lands one cycle after it.
   always_ff @(posedge clk125MHz) begin
      if (rstb) begin
         div_cnt  <= '0;
         adv_data <= 1'b0;
      end else begin
         if ((state != ST_RUN) || (speed == SPD_NONE) || (speed == SPD_1000) || commit)
            div_cnt <= '0;
         else if (div_cnt == div_last)
            div_cnt <= '0;
         else
            div_cnt <= div_cnt + DVW'(1);

         adv_data <= (state == ST_RUN) && !phy_rst_req && !commit &&
                     ((speed == SPD_1000) || ((speed != SPD_NONE) && (div_cnt == '0)));
      end
   end

endmodule
